// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter and its priority picker.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RECOVER = 2'd2
  } arb_state_t;

  localparam logic [31:0] ARB_ABORT_DATA = 32'hDEAD_BEEF;

  // Width of an index into n requesters; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping to 0.
module rr_priority_picker
  import bus_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int LW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper_req;

  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < N; i++) begin
      upper_mask[i] = (i > int'(last));
    end
  end

  assign upper_req = req & upper_mask;

  // Lowest set bit of the hosts above 'last', else lowest set bit overall (wrap-around).
  assign grant = (|upper_req) ? (upper_req & (~upper_req + N'(1)))
                              : (req & (~req + N'(1)));

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter granting one whole ren/wen transaction at a time to one of NHOSTS masters.
// Optional BUS_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts with 0xDEADBEEF and a sticky bus_error.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int NHOSTS  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [32*NHOSTS-1:0]   host_address,
  input  logic [32*NHOSTS-1:0]   host_data_write,
  input  logic [4*NHOSTS-1:0]    host_write_mask,
  input  logic [NHOSTS-1:0]      host_ren,
  input  logic [NHOSTS-1:0]      host_wen,
  output logic [31:0]            host_data_read,
  output logic [NHOSTS-1:0]      host_ready,
  output logic [31:0]            dev_address,
  output logic [31:0]            dev_data_write,
  output logic [3:0]             dev_write_mask,
  output logic                   dev_ren,
  output logic                   dev_wen,
  input  logic [31:0]            dev_data_read,
  input  logic                   dev_ready,
  output logic [NHOSTS-1:0]      grant,
  output logic                   busy,
  output logic [1:0]             dbg_state
`ifdef BUS_ARB_TIMEOUT_EN
  ,
  output logic                   bus_error
`endif
);

  localparam int LW = idx_width(NHOSTS);

  if (NHOSTS < 2 || NHOSTS > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("bus_arbiter_rr: NHOSTS must be 2..8 and TIMEOUT at least 1");
  end

  arb_state_t        state;
  logic [NHOSTS-1:0] req;
  logic [NHOSTS-1:0] pick;
  logic [LW-1:0]     last;
  logic [LW-1:0]     grant_idx;
  logic              done;
  logic              abort;

  assign req = host_ren | host_wen;

  rr_priority_picker #(.N(NHOSTS)) u_picker (
    .req   (req),
    .last  (last),
    .grant (pick)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0] busy_cnt;

  // busy_cnt is 0 in the first BUSY cycle, so the abort lands in BUSY cycle TIMEOUT.
  assign abort = (state == ARB_BUSY) && !dev_ready && (busy_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt  <= '0;
      bus_error <= 1'b0;
    end else begin
      if (state == ARB_BUSY) busy_cnt <= busy_cnt + 16'd1;
      else                   busy_cnt <= '0;
      if (abort) bus_error <= 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  assign done = (state == ARB_BUSY) && (dev_ready || abort);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      grant <= '0;
      last  <= LW'(NHOSTS - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|req) begin
            grant <= pick;
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (done) begin
            last  <= grant_idx;
            grant <= '0;
            state <= ARB_RECOVER;
          end
        end
        ARB_RECOVER: state <= ARB_IDLE;
        default:     state <= ARB_IDLE;
      endcase
    end
  end

  // grant is only non-zero in BUSY, so it alone gates the forwarding path.
  always_comb begin
    dev_address    = '0;
    dev_data_write = '0;
    dev_write_mask = '0;
    dev_ren        = 1'b0;
    dev_wen        = 1'b0;
    grant_idx      = '0;
    for (int i = 0; i < NHOSTS; i++) begin
      if (state == ARB_BUSY && grant[i]) begin
        dev_address    = host_address[32*i +: 32];
        dev_data_write = host_data_write[32*i +: 32];
        dev_write_mask = host_write_mask[4*i +: 4];
        dev_ren        = host_ren[i];
        dev_wen        = host_wen[i];
        grant_idx      = LW'(i);
      end
    end
  end

  assign host_ready     = done ? grant : '0;
  assign host_data_read = !done ? 32'd0 : (abort ? ARB_ABORT_DATA : dev_data_read);
  assign busy           = (state == ARB_BUSY);
  assign dbg_state      = state;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: scoreboard of expected {host_ready, host_data_read} completions.
module tb_bus_arbiter_rr;
  import bus_arb_pkg::*;

  localparam int NH = 2;
  localparam int W  = NH + 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [32*NH-1:0] host_address    = '0;
  logic [32*NH-1:0] host_data_write = '0;
  logic [4*NH-1:0]  host_write_mask = '0;
  logic [NH-1:0]    host_ren        = '0;
  logic [NH-1:0]    host_wen        = '0;
  logic [31:0]      host_data_read;
  logic [NH-1:0]    host_ready;
  logic [31:0]      dev_address, dev_data_write, dev_data_read;
  logic [3:0]       dev_write_mask;
  logic             dev_ren, dev_wen, dev_ready;
  logic [NH-1:0]    grant;
  logic             busy;
  logic [1:0]       dbg_state;
`ifdef BUS_ARB_TIMEOUT_EN
  logic             bus_error;
`endif

  bus_arbiter_rr #(.NHOSTS(NH), .TIMEOUT(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .host_address    (host_address),
    .host_data_write (host_data_write),
    .host_write_mask (host_write_mask),
    .host_ren        (host_ren),
    .host_wen        (host_wen),
    .host_data_read  (host_data_read),
    .host_ready      (host_ready),
    .dev_address     (dev_address),
    .dev_data_write  (dev_data_write),
    .dev_write_mask  (dev_write_mask),
    .dev_ren         (dev_ren),
    .dev_wen         (dev_wen),
    .dev_data_read   (dev_data_read),
    .dev_ready       (dev_ready),
    .grant           (grant),
    .busy            (busy),
    .dbg_state       (dbg_state)
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    .bus_error       (bus_error)
`endif
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // Device model: ready in the dev_delay-th strobe cycle (0 = never); stray forces dev_ready.
  int          dev_delay   = 1;
  int          dev_cnt     = 0;
  logic        model_ready = 1'b0;
  logic        stray       = 1'b0;
  logic        echo_addr   = 1'b0;
  logic [31:0] fixed_rdata = '0;

  assign dev_ready     = model_ready | stray;
  assign dev_data_read = echo_addr ? dev_address : fixed_rdata;

  initial forever begin
    @(posedge clk);
    #1;
    if ((dev_ren || dev_wen) && dev_delay > 0) begin
      dev_cnt++;
      model_ready = (dev_cnt == dev_delay);
    end else begin
      dev_cnt     = 0;
      model_ready = 1'b0;
    end
  end

  // Monitor: every completion pulse must match the head of the expected queue.
  initial forever begin
    logic [W-1:0] exp_v;
    @(negedge clk);
    if (host_ready != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ready: got ready=%b data=%h, required no completion", host_ready, host_data_read);
      end else begin
        exp_v = exp_q.pop_front();
        if ({host_ready, host_data_read} !== exp_v) begin
          failures++;
          $display("FAIL completion: got ready=%b data=%h, required ready=%b data=%h",
                   host_ready, host_data_read, exp_v[W-1:32], exp_v[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic wait_grant(input string name);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (grant != '0) return;
    end
    checks++;
    failures++;
    $display("FAIL %s_grant_timeout: got grant=%b, required a grant within 40 cycles", name, grant);
  endtask

  // Counts BUSY cycles from the current negedge; returns at the first negedge with grant low.
  task automatic count_busy(output int n);
    n = 0;
    while (grant != '0 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, start_c, end_c;

    // Reset state
    @(negedge clk);
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(ARB_IDLE));
    check("rst_dev_strobes", 64'({dev_ren, dev_wen}), 64'(0));
    check("rst_dev_addr", 64'(dev_address), 64'(0));
`ifdef BUS_ARB_TIMEOUT_EN
    check("rst_bus_error", 64'(bus_error), 64'(0));
`endif
    rst = 1'b0;

    // 1: single host read, device ready in the second BUSY cycle
    dev_delay = 2; echo_addr = 1'b0; fixed_rdata = 32'h1234_5678;
    @(negedge clk);
    host_address[31:0] = 32'h0000_0100;
    host_ren = 2'b01;
    exp_q.push_back({2'b01, 32'h1234_5678});
    wait_grant("t1");
    check("t1_grant", 64'(grant), 64'(2'b01));
    check("t1_dev_ren", 64'(dev_ren), 64'(1));
    check("t1_dev_addr", 64'(dev_address), 64'(32'h100));
    count_busy(n);
    check("t1_busy_cycles", 64'(n), 64'(2));
    host_ren = 2'b00;
    check("t1_recover_state", 64'(dbg_state), 64'(ARB_RECOVER));
    check("t1_recover_strobe", 64'(dev_ren), 64'(0));

    // 2: contention, grants alternate with a 2-cycle gap
    do_reset();
    dev_delay = 1; echo_addr = 1'b1;
    host_address = {32'h0000_2000, 32'h0000_1000};
    host_ren = 2'b11;
    for (int t = 0; t < 6; t++)
      exp_q.push_back((t % 2 == 0) ? {2'b01, 32'h0000_1000} : {2'b10, 32'h0000_2000});
    end_c = 0;
    for (int t = 0; t < 6; t++) begin
      wait_grant("t2");
      start_c = cyc;
      check("t2_grant", 64'(grant), (t % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      if (t > 0) check("t2_gap", 64'(start_c - end_c - 1), 64'(2));
      count_busy(n);
      end_c = cyc - 1;
    end
    host_ren = 2'b00;

    // 3: write forwarded from host1 unchanged
    dev_delay = 3; echo_addr = 1'b0; fixed_rdata = 32'h0;
    host_address    = {32'h2000_0000, 32'h0000_0444};
    host_data_write = {32'hCAFE_F00D, 32'h1111_1111};
    host_write_mask = {4'b0011, 4'b1111};
    host_wen = 2'b10;
    exp_q.push_back({2'b10, 32'h0});
    wait_grant("t3");
    n = 0;
    while (grant != '0 && n < 40) begin
      check("t3_dev_addr", 64'(dev_address), 64'(32'h2000_0000));
      check("t3_dev_wdata", 64'(dev_data_write), 64'(32'hCAFE_F00D));
      check("t3_dev_wmask", 64'(dev_write_mask), 64'(4'b0011));
      check("t3_dev_strobes", 64'({dev_ren, dev_wen}), 64'(2'b01));
      check("t3_host0_ready", 64'(host_ready[0]), 64'(0));
      n++;
      @(negedge clk);
    end
    check("t3_busy_cycles", 64'(n), 64'(3));
    host_wen = 2'b00;
    check("t3_recover_wen", 64'(dev_wen), 64'(0));
    check("t3_recover_addr", 64'(dev_address), 64'(0));

    // 4: async reset mid-BUSY, then host0 wins the first contended grant
    dev_delay = 0;
    host_ren = 2'b10;
    wait_grant("t4");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_grant", 64'(grant), 64'(0));
    check("t4_rst_strobes", 64'({dev_ren, dev_wen}), 64'(0));
    check("t4_rst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    dev_delay = 1; fixed_rdata = 32'h0BAD_F00D;
    host_ren = 2'b11;
    exp_q.push_back({2'b01, 32'h0BAD_F00D});
    wait_grant("t4b");
    check("t4_first_grant", 64'(grant), 64'(2'b01));
    count_busy(n);
    host_ren = 2'b00;

    // 5: stray dev_ready in IDLE and in RECOVER is ignored
    @(negedge clk);
    stray = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t5_idle_state", 64'(dbg_state), 64'(ARB_IDLE));
      check("t5_idle_ready", 64'(host_ready), 64'(0));
    end
    stray = 1'b0;
    fixed_rdata = 32'h5A5A_0001;
    host_ren = 2'b01;
    exp_q.push_back({2'b01, 32'h5A5A_0001});
    wait_grant("t5");
    count_busy(n);
    host_ren = 2'b00;
    stray = 1'b1;
    #1;
    check("t5_recover_state", 64'(dbg_state), 64'(ARB_RECOVER));
    check("t5_recover_ready", 64'(host_ready), 64'(0));
    @(negedge clk);
    check("t5_after_state", 64'(dbg_state), 64'(ARB_IDLE));
    check("t5_after_ready", 64'(host_ready), 64'(0));
    stray = 1'b0;

`ifdef BUS_ARB_TIMEOUT_EN
    // 6: device never ready, abort in BUSY cycle 8
    check("t6_err_before", 64'(bus_error), 64'(0));
    dev_delay = 0;
    host_ren = 2'b01;
    exp_q.push_back({2'b01, 32'hDEAD_BEEF});
    wait_grant("t6");
    count_busy(n);
    check("t6_busy_cycles", 64'(n), 64'(8));
    check("t6_bus_error", 64'(bus_error), 64'(1));
    host_ren = 2'b00;
    repeat (3) @(negedge clk);
    check("t6_bus_error_sticky", 64'(bus_error), 64'(1));
`endif

    // Final report
    repeat (3) @(negedge clk);
    check("leftover_expected", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
